// File: rtl/cpu_types_pkg.sv
// Shared CPU-wide types: machine word and RAM handshake state.
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
endpackage

// File: rtl/mem_arb_pkg.sv
// Types and helpers for the icache/dcache RAM-port arbiter.
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, IGRANT, DGRANT} arb_state_t;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side and RAM-side signals of the shared memory port.
interface mem_arbiter_if;
  import cpu_types_pkg::*;

  logic      iREN;
  word_t     iaddr;
  logic      iwait;
  word_t     iload;
  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  logic      dwait;
  word_t     dload;
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;
  logic      mem_err;

  modport master (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, mem_err
  );

  modport slave (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, mem_err
  );
endinterface

// File: rtl/arb_watchdog.sv
// Grant-stall watchdog: counts cycles without completion, flags expiry at TIMEOUT_CYCLES-1.
module arb_watchdog
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic CLK,
  input  logic nRST,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int W = cnt_width(TIMEOUT_CYCLES);

  logic [W-1:0] wd_cnt;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)                wd_cnt <= '0;
    else if (clr)             wd_cnt <= '0;
    else if (en && !expired)  wd_cnt <= wd_cnt + W'(1);
  end

  // A zero limit disables the watchdog entirely.
  if (TIMEOUT_CYCLES == 0) begin : g_off
    assign expired = 1'b0;
  end else begin : g_on
    assign expired = (wd_cnt == W'(TIMEOUT_CYCLES - 1));
  end
endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between fetch and data paths: data priority, fetch starvation guard,
// sticky error flag and stall watchdog.
module mem_arbiter
  import cpu_types_pkg::*;
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic          CLK,
  input  logic          nRST,
  mem_arbiter_if.master bus
);
  localparam int SW = cnt_width(STARVE_LIMIT + 1);

  arb_state_t    state, next_state;
  logic [SW-1:0] starve_cnt;
  logic          mem_err_q;
  logic          done;
  logic          set_err;
  logic          wd_expired;
  logic          starve_full;

  assign starve_full = bus.iREN && (starve_cnt == SW'(STARVE_LIMIT));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= next_state;
  end

  // NOTE: every output gets a default first, so no path through the case can infer a latch.
  always_comb begin
    next_state   = state;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    bus.iwait    = 1'b1;
    bus.dwait    = 1'b1;
    bus.iload    = '0;
    bus.dload    = '0;
    done         = 1'b0;
    set_err      = 1'b0;
    unique case (state)
      IDLE: begin
        if ((bus.dREN || bus.dWEN) && !starve_full) next_state = DGRANT;
        else if (bus.iREN)                          next_state = IGRANT;
      end
      IGRANT: begin
        bus.ramaddr = bus.iaddr;
        if (!bus.iREN) begin
          next_state = IDLE;
        end else begin
          bus.ramREN = 1'b1;
          if (bus.ramstate == ACCESS || bus.ramstate == ERROR) begin
            bus.iwait  = 1'b0;
            bus.iload  = bus.ramload;
            set_err    = (bus.ramstate == ERROR);
            done       = 1'b1;
            next_state = IDLE;
          end else if (wd_expired) begin
            bus.iwait  = 1'b0;
            set_err    = 1'b1;
            done       = 1'b1;
            next_state = IDLE;
          end
        end
      end
      DGRANT: begin
        bus.ramaddr  = bus.daddr;
        bus.ramstore = bus.dstore;
        if (!(bus.dREN || bus.dWEN)) begin
          next_state = IDLE;
        end else begin
          bus.ramWEN = bus.dWEN;
          bus.ramREN = bus.dREN && !bus.dWEN;
          if (bus.ramstate == ACCESS || bus.ramstate == ERROR) begin
            bus.dwait  = 1'b0;
            bus.dload  = bus.ramload;
            set_err    = (bus.ramstate == ERROR);
            done       = 1'b1;
            next_state = IDLE;
          end else if (wd_expired) begin
            bus.dwait  = 1'b0;
            set_err    = 1'b1;
            done       = 1'b1;
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Counts data grants won while fetch waited; cleared whenever fetch is served.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      starve_cnt <= '0;
    end else if (state == IDLE && next_state == DGRANT) begin
      if (bus.iREN && starve_cnt != SW'(STARVE_LIMIT)) starve_cnt <= starve_cnt + SW'(1);
    end else if (state == IDLE && next_state == IGRANT) begin
      starve_cnt <= '0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)        mem_err_q <= 1'b0;
    else if (set_err) mem_err_q <= 1'b1;
  end

  // The flag rises in the failing cycle itself, then holds until reset.
  assign bus.mem_err = mem_err_q || set_err;

  arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .CLK     (CLK),
    .nRST    (nRST),
    .clr     (state == IDLE),
    .en      (state != IDLE && !done),
    .expired (wd_expired)
  );
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inputs change on the falling edge, outputs checked 1ns later.
module tb_mem_arbiter;
  import cpu_types_pkg::*;
  import mem_arb_pkg::*;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 CLK = ~CLK;

  mem_arbiter_if bus ();

  mem_arbiter #(
    .STARVE_LIMIT  (4),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(negedge CLK);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " ramREN"},   32'(bus.ramREN),  0);
    check({tag, " ramWEN"},   32'(bus.ramWEN),  0);
    check({tag, " ramaddr"},  bus.ramaddr,      0);
    check({tag, " ramstore"}, bus.ramstore,     0);
    check({tag, " iwait"},    32'(bus.iwait),   1);
    check({tag, " dwait"},    32'(bus.dwait),   1);
    check({tag, " iload"},    bus.iload,        0);
    check({tag, " dload"},    bus.dload,        0);
    check({tag, " mem_err"},  32'(bus.mem_err), 0);
  endtask

  initial begin
    bus.iREN = 0; bus.iaddr = 0; bus.dREN = 0; bus.dWEN = 0;
    bus.daddr = 0; bus.dstore = 0; bus.ramload = 0; bus.ramstate = FREE;

    // Reset state
    #2;
    check_reset_outputs("rst");
    next_cycle();
    nRST = 1'b1;

    // 1. Fetch only: two BUSY cycles then ACCESS
    next_cycle(); bus.iREN = 1; bus.iaddr = 32'h40; settle();
    check("t1 req ramREN", 32'(bus.ramREN), 0);
    next_cycle(); bus.ramstate = BUSY; settle();
    check("t1 grant ramREN", 32'(bus.ramREN), 1);
    check("t1 grant ramaddr", bus.ramaddr, 32'h40);
    check("t1 busy1 iwait", 32'(bus.iwait), 1);
    next_cycle(); settle();
    check("t1 busy2 iwait", 32'(bus.iwait), 1);
    next_cycle(); bus.ramstate = ACCESS; bus.ramload = 32'h8C010004; settle();
    check("t1 done iwait", 32'(bus.iwait), 0);
    check("t1 done iload", bus.iload, 32'h8C010004);
    check("t1 done dwait", 32'(bus.dwait), 1);
    next_cycle(); bus.iREN = 0; bus.ramstate = FREE; settle();
    check("t1 after iwait", 32'(bus.iwait), 1);
    check("t1 after iload", bus.iload, 0);

    // 2. Simultaneous requests: data first, one idle cycle, then fetch
    next_cycle(); bus.iREN = 1; bus.iaddr = 32'h44; bus.dREN = 1; bus.daddr = 32'h100; settle();
    next_cycle(); bus.ramstate = ACCESS; bus.ramload = 32'h11; settle();
    check("t2 d ramaddr", bus.ramaddr, 32'h100);
    check("t2 d ramREN", 32'(bus.ramREN), 1);
    check("t2 d dwait", 32'(bus.dwait), 0);
    check("t2 d dload", bus.dload, 32'h11);
    check("t2 d iwait", 32'(bus.iwait), 1);
    next_cycle(); bus.dREN = 0; bus.ramstate = FREE; settle();
    check("t2 idle ramREN", 32'(bus.ramREN), 0);
    check("t2 idle starve", 32'(dut.starve_cnt), 1);
    next_cycle(); bus.ramstate = ACCESS; bus.ramload = 32'h22; settle();
    check("t2 i ramaddr", bus.ramaddr, 32'h44);
    check("t2 i iwait", 32'(bus.iwait), 0);
    check("t2 i iload", bus.iload, 32'h22);
    next_cycle(); bus.iREN = 0; bus.ramstate = FREE; settle();
    check("t2 starve cleared", 32'(dut.starve_cnt), 0);

    // 3. Starvation guard: four data grants, then fetch forced
    next_cycle(); bus.iREN = 1; bus.iaddr = 32'h48; bus.dREN = 1; bus.daddr = 32'h300; settle();
    for (int g = 0; g < 4; g++) begin
      next_cycle(); bus.ramstate = ACCESS; bus.ramload = 32'(g); settle();
      check($sformatf("t3 d%0d ramaddr", g), bus.ramaddr, 32'h300);
      check($sformatf("t3 d%0d dwait", g), 32'(bus.dwait), 0);
      next_cycle(); bus.ramstate = FREE; settle();
      check($sformatf("t3 d%0d idle", g), 32'(bus.ramREN), 0);
    end
    check("t3 starve full", 32'(dut.starve_cnt), 4);
    next_cycle(); bus.ramstate = ACCESS; bus.ramload = 32'h99; settle();
    check("t3 forced ramaddr", bus.ramaddr, 32'h48);
    check("t3 forced iwait", 32'(bus.iwait), 0);
    check("t3 forced dwait", 32'(bus.dwait), 1);
    check("t3 starve zero", 32'(dut.starve_cnt), 0);
    next_cycle(); bus.iREN = 0; bus.dREN = 0; bus.ramstate = FREE; settle();

    // 4. Write: write wins when both enables are set
    next_cycle(); bus.dREN = 1; bus.dWEN = 1; bus.daddr = 32'h200; bus.dstore = 32'hDEADBEEF; settle();
    next_cycle(); bus.ramstate = BUSY; settle();
    check("t4 ramWEN", 32'(bus.ramWEN), 1);
    check("t4 ramREN", 32'(bus.ramREN), 0);
    check("t4 ramstore", bus.ramstore, 32'hDEADBEEF);
    check("t4 ramaddr", bus.ramaddr, 32'h200);
    next_cycle(); bus.ramstate = ACCESS; bus.ramload = 0; settle();
    check("t4 dwait", 32'(bus.dwait), 0);
    check("t4 dload", bus.dload, 0);
    next_cycle(); bus.dREN = 0; bus.dWEN = 0; bus.ramstate = FREE; settle();

    // 5a. Watchdog: RAM stuck BUSY, dwait falls on grant cycle 8
    next_cycle(); bus.dREN = 1; bus.daddr = 32'h400; bus.ramstate = BUSY; bus.ramload = 32'hAAAA5555; settle();
    for (int k = 1; k <= 7; k++) begin
      next_cycle(); settle();
      check($sformatf("t5 busy%0d dwait", k), 32'(bus.dwait), 1);
    end
    check("t5 before mem_err", 32'(bus.mem_err), 0);
    next_cycle(); settle();
    check("t5 timeout dwait", 32'(bus.dwait), 0);
    check("t5 timeout dload", bus.dload, 0);
    check("t5 timeout mem_err", 32'(bus.mem_err), 1);
    next_cycle(); bus.dREN = 0; bus.ramstate = FREE; settle();
    check("t5 sticky mem_err", 32'(bus.mem_err), 1);
    check("t5 idle dwait", 32'(bus.dwait), 1);

    // 6a. Asynchronous reset in the middle of a data grant
    next_cycle(); bus.dREN = 1; bus.daddr = 32'h500; bus.ramstate = BUSY; settle();
    next_cycle(); settle();
    check("t6 pre-rst ramREN", 32'(bus.ramREN), 1);
    #1 nRST = 1'b0; settle();
    check_reset_outputs("t6 rst");
    next_cycle(); bus.dREN = 0; bus.ramstate = FREE; nRST = 1'b1; settle();

    // 5b. RAM ERROR completion sets the sticky flag
    next_cycle(); bus.dREN = 1; bus.daddr = 32'h600; settle();
    next_cycle(); bus.ramstate = ERROR; bus.ramload = 32'h5; settle();
    check("t5e dwait", 32'(bus.dwait), 0);
    check("t5e dload", bus.dload, 32'h5);
    check("t5e mem_err", 32'(bus.mem_err), 1);
    next_cycle(); bus.dREN = 0; bus.ramstate = FREE; settle();
    check("t5e sticky mem_err", 32'(bus.mem_err), 1);

    // 6b. Abort: request dropped mid-grant
    next_cycle(); bus.dREN = 1; bus.daddr = 32'h700; bus.ramstate = BUSY; settle();
    next_cycle(); settle();
    check("t6 abort pre ramREN", 32'(bus.ramREN), 1);
    next_cycle(); bus.dREN = 0; settle();
    check("t6 abort ramREN", 32'(bus.ramREN), 0);
    check("t6 abort dwait", 32'(bus.dwait), 1);
    next_cycle(); bus.ramstate = ACCESS; bus.ramload = 32'h77; settle();
    check("t6 abort state", 32'(dut.state), 32'(IDLE));
    check("t6 abort dload", bus.dload, 0);
    check("t6 abort dwait idle", 32'(bus.dwait), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
